// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared CPU constants and next-PC state encoding
// Purpose: reset/exception PC defaults shared by the PC generator and fetch stage,
//          plus the 1-bit redirect-buffer state encoding.
// Ports:   none (package).
package cpu_defs_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;

  // ST_RUN: no buffered redirect; ST_HOLD: a redirect waits for stall release.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_stage.sv
// rtl/pc_gen_stage.sv - next-PC generator feeding the fetch stage
// Purpose: owns the PC register and selects among sequential, branch/jump,
//          exception-vector and ERET targets; buffers a branch that arrives
//          during a stall and applies it when the stall releases.
// Ports:
//   clk             in   pipeline clock
//   resetn          in   asynchronous active-low reset
//   stall           in   hold PC (same stall the fetch stage sees)
//   br_taken        in   taken branch/jump pulse from decode
//   br_target [31:0] in  redirect target, valid with br_taken
//   exception       in   exception commit pulse
//   eret            in   ERET commit pulse
//   epc [31:0]      in   return address, valid with eret
//   inst_sram_en    out  instruction read enable
//   inst_sram_raddr out  fetch address (the PC register)
//   if_adel         out  fetch address misaligned
//   redir_pending   out  a buffered branch redirect is waiting
module pc_gen_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exception,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_raddr,
  output logic        if_adel,
  output logic        redir_pending
);

  pc_state_e   state, state_nxt;
  logic [31:0] pc_reg, pc_nxt;
  logic [31:0] pend_tgt, pend_nxt;
  logic        en_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_RUN;
      pc_reg   <= RESET_PC;
      pend_tgt <= 32'h0;
      en_reg   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_reg   <= pc_nxt;
      pend_tgt <= pend_nxt;
      en_reg   <= 1'b1;
    end
  end

  // Single priority chain: exception > eret > stall(+branch capture) >
  // live branch > buffered branch > sequential.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_reg;
    pend_nxt  = pend_tgt;
    if (exception) begin
      pc_nxt    = EXC_VECTOR;
      state_nxt = ST_RUN;
    end else if (eret) begin
      pc_nxt    = epc;
      state_nxt = ST_RUN;
    end else if (stall) begin
      // A newer branch during a stall simply replaces the buffered one.
      if (br_taken) begin
        pend_nxt  = br_target;
        state_nxt = ST_HOLD;
      end
    end else if (br_taken) begin
      pc_nxt    = br_target;
      state_nxt = ST_RUN;
    end else if (state == ST_HOLD) begin
      pc_nxt    = pend_tgt;
      state_nxt = ST_RUN;
    end else begin
      pc_nxt = pc_reg + 32'd4;
    end
  end

  assign inst_sram_en    = en_reg;
  assign inst_sram_raddr = pc_reg;
  assign if_adel         = (pc_reg[1:0] != 2'b00);
  assign redir_pending   = (state == ST_HOLD);

endmodule

// File: tb/tb_pc_gen_stage.sv
// tb/tb_pc_gen_stage.sv - self-checking bench for pc_gen_stage
module tb_pc_gen_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exception;
  logic        eret;
  logic [31:0] epc;
  logic        inst_sram_en;
  logic [31:0] inst_sram_raddr;
  logic        if_adel;
  logic        redir_pending;

  int checks = 0;
  int errors = 0;

  pc_gen_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .exception       (exception),
    .eret            (eret),
    .epc             (epc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_raddr (inst_sram_raddr),
    .if_adel         (if_adel),
    .redir_pending   (redir_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_adel;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic x, input logic e, input logic [31:0] ep,
                              input logic [31:0] pc, input logic pend, input logic adel);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.exc = x; v.eret = e; v.epc = ep;
    v.exp_pc = pc; v.exp_pend = pend; v.exp_adel = adel;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic x, input logic e, input logic [31:0] ep);
    stall = s; br_taken = b; br_target = t; exception = x; eret = e; epc = ep;
  endtask

  initial begin
    //              stall br  tgt           exc eret epc           exp_pc        pend adel
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00004, 0, 0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00008, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0000c, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00010, 0, 0);
    vecs[4]  = mk(0, 1, 32'hbfc00100, 0, 0, 32'h0,        32'hbfc00100, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00104, 0, 0);
    vecs[6]  = mk(1, 1, 32'hbfc00200, 0, 0, 32'h0,        32'hbfc00104, 1, 0);
    vecs[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00104, 1, 0);
    vecs[8]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00104, 1, 0);
    vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00200, 0, 0);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00204, 0, 0);
    vecs[11] = mk(1, 1, 32'hbfc00300, 0, 0, 32'h0,        32'hbfc00204, 1, 0);
    vecs[12] = mk(1, 1, 32'hbfc00400, 0, 0, 32'h0,        32'hbfc00204, 1, 0);
    vecs[13] = mk(0, 1, 32'hbfc00500, 0, 0, 32'h0,        32'hbfc00500, 0, 0);
    vecs[14] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00504, 0, 0);
    vecs[15] = mk(1, 1, 32'hbfc00600, 0, 0, 32'h0,        32'hbfc00504, 1, 0);
    vecs[16] = mk(1, 0, 32'h0,        1, 0, 32'h0,        32'hbfc00380, 0, 0);
    vecs[17] = mk(1, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00380, 0, 0);
    vecs[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc00384, 0, 0);
    vecs[19] = mk(0, 0, 32'h0,        1, 1, 32'hbfc01234, 32'hbfc00380, 0, 0);
    vecs[20] = mk(1, 0, 32'h0,        0, 1, 32'hbfc01234, 32'hbfc01234, 0, 0);
    vecs[21] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc01238, 0, 0);
    vecs[22] = mk(1, 1, 32'hbfc00700, 0, 0, 32'h0,        32'hbfc01238, 1, 0);
    vecs[23] = mk(1, 0, 32'h0,        0, 1, 32'hbfc01236, 32'hbfc01236, 0, 1);
    vecs[24] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hbfc0123a, 0, 1);
    vecs[25] = mk(0, 1, 32'hfffffffc, 0, 0, 32'h0,        32'hfffffffc, 0, 0);
    vecs[26] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h00000000, 0, 0);
    vecs[27] = mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h00000004, 0, 0);

    drive(0, 0, 32'h0, 0, 0, 32'h0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset raddr", inst_sram_raddr, 32'hbfc00000);
    check("reset en", {31'b0, inst_sram_en}, 32'd0);
    check("reset pend", {31'b0, redir_pending}, 32'd0);
    check("reset adel", {31'b0, if_adel}, 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].exc, vecs[i].eret, vecs[i].epc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d raddr", i), inst_sram_raddr, vecs[i].exp_pc);
      check($sformatf("v%0d pend", i), {31'b0, redir_pending}, {31'b0, vecs[i].exp_pend});
      check($sformatf("v%0d adel", i), {31'b0, if_adel}, {31'b0, vecs[i].exp_adel});
      check($sformatf("v%0d en", i), {31'b0, inst_sram_en}, 32'd1);
    end

    // Reset asserted while a redirect is buffered: pending target must be lost.
    drive(1, 1, 32'hbfc00800, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    check("hold pend before reset", {31'b0, redir_pending}, 32'd1);
    check("hold raddr before reset", inst_sram_raddr, 32'h00000004);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset raddr", inst_sram_raddr, 32'hbfc00000);
    check("async reset pend", {31'b0, redir_pending}, 32'd0);
    check("async reset en", {31'b0, inst_sram_en}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post reset raddr", inst_sram_raddr, 32'hbfc00004);
    check("post reset en", {31'b0, inst_sram_en}, 32'd1);
    check("post reset pend", {31'b0, redir_pending}, 32'd0);
    @(posedge clk);
    #1;
    check("post reset raddr2", inst_sram_raddr, 32'hbfc00008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
